// File: rtl/axi_byte_mem_slave_pkg.sv
// ---------------------------------------------------------------------------
// axi_byte_mem_slave_pkg
// Shared types for the AXI4 byte-memory slave tile: channel widths, response
// and burst codes, the write/read FSM state encodings, and the bundled
// master-to-slave (mosi) / slave-to-master (miso) channel structs.
// ---------------------------------------------------------------------------
package axi_byte_mem_slave_pkg;

  localparam int ID_W_WIDTH     = 4;
  localparam int ID_R_WIDTH     = 4;
  localparam int ADDR_WIDTH     = 16;
  localparam int AXI_DATA_WIDTH = 8;
  localparam int STRB_WIDTH     = AXI_DATA_WIDTH / 8;
  localparam int LEN_WIDTH      = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  typedef struct packed {
    logic                      aw_valid;
    logic [ID_W_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [LEN_WIDTH-1:0]      aw_len;
    burst_e                    aw_burst;
    logic                      w_valid;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_last;
    logic                      b_ready;
    logic                      ar_valid;
    logic [ID_R_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [LEN_WIDTH-1:0]      ar_len;
    burst_e                    ar_burst;
    logic                      r_ready;
  } axi_mosi_t;

  typedef struct packed {
    logic                      aw_ready;
    logic                      w_ready;
    logic                      b_valid;
    logic [ID_W_WIDTH-1:0]     b_id;
    resp_e                     b_resp;
    logic                      ar_ready;
    logic                      r_valid;
    logic [ID_R_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    resp_e                     r_resp;
    logic                      r_last;
  } axi_miso_t;

endpackage

// File: rtl/axi_byte_mem_slave_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_byte_mem_slave_burst_addr_gen
// Purely combinational address helper for one AXI channel.
//   addr_i      : byte address of the current beat
//   burst_i     : AxBURST of the transaction
//   next_addr_o : address of the following beat (FIXED holds, all else +1)
//   in_window_o : addr_i falls inside [BASE_ADDR, BASE_ADDR+MEM_DEPTH)
//   offset_o    : storage index of addr_i (valid when in_window_o)
//   illegal_o   : WRAP or reserved burst type (served as INCR, flagged)
// ---------------------------------------------------------------------------
module axi_byte_mem_slave_burst_addr_gen
  import axi_byte_mem_slave_pkg::*;
#(
  parameter int                    MEM_DEPTH = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  burst_e                       burst_i,
  output logic [ADDR_WIDTH-1:0]        next_addr_o,
  output logic                         in_window_o,
  output logic [$clog2(MEM_DEPTH)-1:0] offset_o,
  output logic                         illegal_o
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [ADDR_WIDTH-1:0] full_off;

  always_comb begin
    // Modular subtraction: addresses below the base wrap to a huge offset and
    // therefore fall out of the window without a separate lower-bound compare.
    full_off    = addr_i - BASE_ADDR;
    in_window_o = ((full_off >> IDX_W) == '0);
    offset_o    = full_off[IDX_W-1:0];
    illegal_o   = (burst_i == BURST_WRAP) || (burst_i == BURST_RSVD);
    next_addr_o = (burst_i == BURST_FIXED) ? addr_i : addr_i + ADDR_WIDTH'(1);
  end

endmodule

// File: rtl/axi_byte_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_byte_mem_slave
// AXI4 slave backed by a byte-wide flop array. Independent write (AW/W/B) and
// read (AR/R) FSMs share the store through one write port and one read port;
// neither channel ever stalls the other.
//   clk      : clock
//   rst      : synchronous, active-high reset (storage contents are kept)
//   s_mosi_i : AW/W/AR payloads and valids, BREADY, RREADY
//   s_miso_o : AWREADY, WREADY, ARREADY, B and R payloads and valids
// ---------------------------------------------------------------------------
module axi_byte_mem_slave
  import axi_byte_mem_slave_pkg::*;
#(
  parameter int                    MEM_DEPTH = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 16'h1000
) (
  input  logic      clk,
  input  logic      rst,
  input  axi_mosi_t s_mosi_i,
  output axi_miso_t s_miso_o
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  w_state_e                w_state_q, w_state_d;
  logic [ID_W_WIDTH-1:0]   aw_id_q;
  logic [ADDR_WIDTH-1:0]   w_addr_q;
  logic [LEN_WIDTH-1:0]    aw_len_q;
  logic [LEN_WIDTH-1:0]    w_beat_q;
  burst_e                  aw_burst_q;
  logic                    w_dec_q;   // some beat fell outside the window
  logic                    w_slv_q;   // WLAST disagreed with the AWLEN count

  logic                    aw_hs, w_hs, w_last_beat, mem_we;
  logic                    aw_ready, w_ready, b_valid;
  resp_e                   b_resp;
  logic [ADDR_WIDTH-1:0]   w_next_addr;
  logic                    w_in_window, w_illegal;
  logic [IDX_W-1:0]        w_offset;

  axi_byte_mem_slave_burst_addr_gen #(
    .MEM_DEPTH (MEM_DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_w_addr_gen (
    .addr_i      (w_addr_q),
    .burst_i     (aw_burst_q),
    .next_addr_o (w_next_addr),
    .in_window_o (w_in_window),
    .offset_o    (w_offset),
    .illegal_o   (w_illegal)
  );

  assign aw_hs       = s_mosi_i.aw_valid && (w_state_q == W_IDLE);
  assign w_hs        = s_mosi_i.w_valid  && (w_state_q == W_DATA);
  assign w_last_beat = (w_beat_q == aw_len_q);

  // NOTE: state is only ever updated with <= so every flop samples the values
  // of the previous cycle, independent of statement and process order.
  always_ff @(posedge clk) begin
    if (rst) w_state_q <= W_IDLE;
    else     w_state_q <= w_state_d;
  end

  // NOTE: the default assignment first keeps this block purely combinational;
  // a path that left w_state_d unassigned would infer a latch.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (s_mosi_i.aw_valid)                w_state_d = W_DATA;
      // The AWLEN count, not WLAST, ends the burst.
      W_DATA:  if (s_mosi_i.w_valid && w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (s_mosi_i.b_ready)                 w_state_d = W_IDLE;
      default:                                       w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready = (w_state_q == W_IDLE);
    w_ready  = (w_state_q == W_DATA);
    b_valid  = (w_state_q == W_RESP);
    b_resp   = RESP_OKAY;
    if (b_valid) begin
      if (w_dec_q)                    b_resp = RESP_DECERR;
      else if (w_slv_q || w_illegal)  b_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_id_q    <= '0;
      w_addr_q   <= '0;
      aw_len_q   <= '0;
      w_beat_q   <= '0;
      aw_burst_q <= BURST_FIXED;
      w_dec_q    <= 1'b0;
      w_slv_q    <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_id_q    <= s_mosi_i.aw_id;
        w_addr_q   <= s_mosi_i.aw_addr;
        aw_len_q   <= s_mosi_i.aw_len;
        aw_burst_q <= s_mosi_i.aw_burst;
        w_beat_q   <= '0;
        w_dec_q    <= 1'b0;
        w_slv_q    <= 1'b0;
      end
      if (w_hs) begin
        w_addr_q <= w_next_addr;
        w_beat_q <= w_beat_q + LEN_WIDTH'(1);
        if (!w_in_window)                      w_dec_q <= 1'b1;
        if (s_mosi_i.w_last != w_last_beat)    w_slv_q <= 1'b1;
      end
    end
  end

  // Out-of-window beats are consumed but dropped.
  assign mem_we = w_hs && s_mosi_i.w_strb[0] && w_in_window && !rst;

  // NOTE: the byte store has no reset; its contents survive rst by design and
  // a reset branch here would only add a clear path to every flop.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[w_offset] <= s_mosi_i.w_data;
  end

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  r_state_e                  r_state_q, r_state_d;
  logic [ID_R_WIDTH-1:0]     ar_id_q;
  logic [LEN_WIDTH-1:0]      ar_len_q;
  logic [LEN_WIDTH-1:0]      r_beat_q;
  burst_e                    ar_burst_q;
  logic [ADDR_WIDTH-1:0]     r_next_q;  // address of the beat after the one held
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
  resp_e                     r_resp_q;

  logic                      r_idle, ar_hs, r_hs, r_last_beat, r_fetch;
  logic [ADDR_WIDTH-1:0]     r_fetch_addr, r_next_addr;
  burst_e                    r_burst;
  logic                      r_in_window, r_illegal;
  logic [IDX_W-1:0]          r_offset;
  resp_e                     r_resp_d;

  assign r_idle      = (r_state_q == R_IDLE);
  assign ar_hs       = s_mosi_i.ar_valid && r_idle;
  assign r_hs        = s_mosi_i.r_ready && (r_state_q == R_DATA);
  assign r_last_beat = (r_beat_q == ar_len_q);
  // A byte is fetched on the AR handshake (beat 0) and on every non-final R
  // handshake, so the next beat is ready the very next cycle.
  assign r_fetch     = ar_hs || (r_hs && !r_last_beat);

  // In idle the fetch targets the incoming ARADDR, afterwards the
  // precomputed follow-on address.
  assign r_fetch_addr = r_idle ? s_mosi_i.ar_addr  : r_next_q;
  assign r_burst      = r_idle ? s_mosi_i.ar_burst : ar_burst_q;

  axi_byte_mem_slave_burst_addr_gen #(
    .MEM_DEPTH (MEM_DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_r_addr_gen (
    .addr_i      (r_fetch_addr),
    .burst_i     (r_burst),
    .next_addr_o (r_next_addr),
    .in_window_o (r_in_window),
    .offset_o    (r_offset),
    .illegal_o   (r_illegal)
  );

  always_comb begin
    if (!r_in_window)   r_resp_d = RESP_DECERR;
    else if (r_illegal) r_resp_d = RESP_SLVERR;
    else                r_resp_d = RESP_OKAY;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state_q <= R_IDLE;
    else     r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (s_mosi_i.ar_valid)               r_state_d = R_DATA;
      R_DATA:  if (s_mosi_i.r_ready && r_last_beat) r_state_d = R_IDLE;
      default:                                      r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      r_beat_q   <= '0;
      ar_burst_q <= BURST_FIXED;
      r_next_q   <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        ar_id_q    <= s_mosi_i.ar_id;
        ar_len_q   <= s_mosi_i.ar_len;
        ar_burst_q <= s_mosi_i.ar_burst;
        r_beat_q   <= '0;
      end else if (r_hs && !r_last_beat) begin
        r_beat_q <= r_beat_q + LEN_WIDTH'(1);
      end
      // Reads the pre-write value on a same-cycle collision with mem_we.
      if (r_fetch) begin
        r_data_q <= r_in_window ? mem_q[r_offset] : '0;
        r_resp_q <= r_resp_d;
        r_next_q <= r_next_addr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output bundle
  // -------------------------------------------------------------------------
  always_comb begin
    s_miso_o          = '0;
    s_miso_o.aw_ready = aw_ready;
    s_miso_o.w_ready  = w_ready;
    s_miso_o.b_valid  = b_valid;
    s_miso_o.b_id     = aw_id_q;
    s_miso_o.b_resp   = b_resp;
    s_miso_o.ar_ready = r_idle;
    s_miso_o.r_valid  = !r_idle;
    s_miso_o.r_id     = ar_id_q;
    s_miso_o.r_data   = r_data_q;
    s_miso_o.r_resp   = r_resp_q;
    s_miso_o.r_last   = !r_idle && r_last_beat;
  end

endmodule

// File: tb/tb_axi_byte_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_byte_mem_slave
// Directed and randomized AXI traffic against axi_byte_mem_slave, checked
// against a byte-array reference of the storage window and per-beat
// address/response rules.
// ---------------------------------------------------------------------------
module tb_axi_byte_mem_slave;
  import axi_byte_mem_slave_pkg::*;

  localparam int          DEPTH = 4096;
  localparam logic [15:0] BASE  = 16'h1000;

  logic      clk = 1'b0;
  logic      rst;
  axi_mosi_t mosi;
  axi_miso_t miso;

  // Per-channel drive variables so concurrent tasks never share a variable.
  logic        aw_valid, w_valid, w_strb, w_last, b_ready, ar_valid, r_ready;
  logic [3:0]  aw_id, ar_id;
  logic [15:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len, w_data;
  burst_e      aw_burst, ar_burst;

  always_comb begin
    mosi          = '0;
    mosi.aw_valid = aw_valid;
    mosi.aw_id    = aw_id;
    mosi.aw_addr  = aw_addr;
    mosi.aw_len   = aw_len;
    mosi.aw_burst = aw_burst;
    mosi.w_valid  = w_valid;
    mosi.w_data   = w_data;
    mosi.w_strb   = w_strb;
    mosi.w_last   = w_last;
    mosi.b_ready  = b_ready;
    mosi.ar_valid = ar_valid;
    mosi.ar_id    = ar_id;
    mosi.ar_addr  = ar_addr;
    mosi.ar_len   = ar_len;
    mosi.ar_burst = ar_burst;
    mosi.r_ready  = r_ready;
  end

  axi_byte_mem_slave #(
    .MEM_DEPTH (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_mosi_i (mosi),
    .s_miso_o (miso)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [DEPTH];
  logic [7:0] wdat [256];
  logic       wstb [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] beat_addr(input logic [15:0] a, input burst_e b, input int i);
    return (b == BURST_FIXED) ? a : a + 16'(i);
  endfunction

  function automatic bit in_win(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    return off < 16'(DEPTH);
  endfunction

  function automatic bit is_illegal(input burst_e b);
    return (b == BURST_WRAP) || (b == BURST_RSVD);
  endfunction

  // All channel tasks start and end on a falling edge.
  task automatic send_aw(input logic [3:0] id, input logic [15:0] a, input logic [7:0] l, input burst_e b);
    int n = 0;
    aw_id = id; aw_addr = a; aw_len = l; aw_burst = b; aw_valid = 1'b1;
    while (!miso.aw_ready && n < 50) begin @(negedge clk); n++; end
    check("aw_ready_wait", 32'(miso.aw_ready), 1);
    @(negedge clk);
    aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] d, input logic s, input logic last);
    int n = 0;
    w_data = d; w_strb = s; w_last = last; w_valid = 1'b1;
    while (!miso.w_ready && n < 50) begin @(negedge clk); n++; end
    check("w_ready_wait", 32'(miso.w_ready), 1);
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [15:0] a, input logic [7:0] l, input burst_e b);
    int n = 0;
    ar_id = id; ar_addr = a; ar_len = l; ar_burst = b; ar_valid = 1'b1;
    while (!miso.ar_ready && n < 50) begin @(negedge clk); n++; end
    check("ar_ready_wait", 32'(miso.ar_ready), 1);
    @(negedge clk);
    ar_valid = 1'b0;
  endtask

  // Write burst from wdat/wstb; wlast_at is the beat index carrying WLAST.
  task automatic write_burst(input logic [3:0] id, input logic [15:0] a, input logic [7:0] l,
                             input burst_e b, input int wlast_at, input int b_delay);
    bit          dec = 1'b0;
    bit          slv;
    logic [1:0]  exp_resp;
    logic [15:0] ba;
    slv = is_illegal(b);
    for (int i = 0; i <= int'(l); i++) begin
      if (!in_win(beat_addr(a, b, i))) dec = 1'b1;
      if ((i == wlast_at) != (i == int'(l))) slv = 1'b1;
    end
    exp_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);

    send_aw(id, a, l, b);
    check("w_ready_after_aw", 32'(miso.w_ready), 1);
    check("aw_ready_busy", 32'(miso.aw_ready), 0);
    for (int i = 0; i <= int'(l); i++) send_w(wdat[i], wstb[i], i == wlast_at);
    check("b_valid_rise", 32'(miso.b_valid), 1);
    repeat (b_delay) begin
      @(negedge clk);
      check("b_valid_hold", 32'(miso.b_valid), 1);
      check("b_id_hold", 32'(miso.b_id), 32'(id));
    end
    b_ready = 1'b1;
    check("b_id", 32'(miso.b_id), 32'(id));
    check("b_resp", 32'(miso.b_resp), 32'(exp_resp));
    @(negedge clk);
    b_ready = 1'b0;
    check("b_valid_drop", 32'(miso.b_valid), 0);
    check("aw_ready_again", 32'(miso.aw_ready), 1);

    for (int i = 0; i <= int'(l); i++) begin
      ba = beat_addr(a, b, i);
      if (in_win(ba) && wstb[i]) ref_mem[int'(16'(ba - BASE))] = wdat[i];
    end
  endtask

  // mode 0: RREADY always 1; mode 1: RREADY pattern 1,0,0,1; mode 2: random.
  task automatic read_burst(input logic [3:0] id, input logic [15:0] a, input logic [7:0] l,
                            input burst_e b, input int mode);
    logic [7:0]  ed [256];
    logic [1:0]  er [256];
    logic [15:0] ba;
    int          beat = 0;
    int          cyc  = 0;
    bit          rr;
    for (int i = 0; i <= int'(l); i++) begin
      ba = beat_addr(a, b, i);
      if (!in_win(ba)) begin
        ed[i] = 8'h00; er[i] = 2'b11;
      end else begin
        ed[i] = ref_mem[int'(16'(ba - BASE))];
        er[i] = is_illegal(b) ? 2'b10 : 2'b00;
      end
    end

    send_ar(id, a, l, b);
    check("r_valid_after_ar", 32'(miso.r_valid), 1);
    while (beat <= int'(l) && cyc < 2000) begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      r_ready = rr;
      check("r_valid", 32'(miso.r_valid), 1);
      check("r_id", 32'(miso.r_id), 32'(id));
      check("r_data", 32'(miso.r_data), 32'(ed[beat]));
      check("r_resp", 32'(miso.r_resp), 32'(er[beat]));
      check("r_last", 32'(miso.r_last), 32'(beat == int'(l)));
      @(negedge clk);
      if (rr) beat++;
      cyc++;
    end
    r_ready = 1'b0;
    check("r_beats_done", 32'(beat), 32'(int'(l) + 1));
    check("r_valid_drop", 32'(miso.r_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = BURST_INCR;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = BURST_INCR;
    w_data = '0; w_strb = 1'b0; w_last = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_aw_ready", 32'(miso.aw_ready), 1);
    check("rst_ar_ready", 32'(miso.ar_ready), 1);
    check("rst_w_ready",  32'(miso.w_ready), 0);
    check("rst_b_valid",  32'(miso.b_valid), 0);
    check("rst_r_valid",  32'(miso.r_valid), 0);
    check("rst_b_resp",   32'(miso.b_resp), 0);
    check("rst_b_id",     32'(miso.b_id), 0);
    check("rst_r_resp",   32'(miso.r_resp), 0);
    check("rst_r_data",   32'(miso.r_data), 0);
    check("rst_r_id",     32'(miso.r_id), 0);
    rst = 1'b0;

    // Fill the whole window with 256-beat bursts (longest AWLEN).
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 256; i++) begin wdat[i] = 8'($urandom); wstb[i] = 1'b1; end
      write_burst(4'(k), BASE + 16'(k * 256), 8'd255, BURST_INCR, 255, 0);
    end
    read_burst(4'd9, BASE + 16'h0300, 8'd255, BURST_INCR, 0);

    // 1: basic write burst.
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
    for (int i = 0; i < 4; i++) wstb[i] = 1'b1;
    write_burst(4'd2, 16'h1004, 8'd3, BURST_INCR, 3, 0);
    // 2: back-to-back read of the same bytes.
    read_burst(4'd5, 16'h1004, 8'd3, BURST_INCR, 0);
    // 3: stalled R and B handshakes.
    read_burst(4'd5, 16'h1004, 8'd3, BURST_INCR, 1);
    write_burst(4'd7, 16'h1004, 8'd3, BURST_INCR, 3, 5);

    // 4: window edges.
    wdat[0] = 8'hAA; wdat[1] = 8'hBB; wdat[2] = 8'hCC; wdat[3] = 8'hDD;
    write_burst(4'd3, 16'h0FFE, 8'd3, BURST_INCR, 3, 0);
    read_burst(4'd1, 16'h0FFE, 8'd5, BURST_INCR, 0);
    read_burst(4'd4, 16'h1FFE, 8'd3, BURST_INCR, 0);

    // 5: protocol errors and burst types.
    wdat[0] = 8'h01; wdat[1] = 8'h02; wdat[2] = 8'h03; wdat[3] = 8'h04;
    write_burst(4'd6, 16'h1200, 8'd3, BURST_INCR, 1, 0);    // early WLAST
    write_burst(4'd6, 16'h1210, 8'd3, BURST_INCR, 255, 0);  // missing WLAST
    write_burst(4'd8, 16'h1220, 8'd3, BURST_WRAP, 3, 1);
    write_burst(4'd8, 16'h1230, 8'd3, BURST_FIXED, 3, 0);
    read_burst(4'd2, 16'h1200, 8'd3, BURST_WRAP, 0);
    read_burst(4'd3, 16'h1230, 8'd2, BURST_FIXED, 0);
    write_burst(4'd9, 16'h0FFC, 8'd3, BURST_WRAP, 1, 0);    // DECERR beats SLVERR

    // 6a: concurrent write and read of the same bytes; every read fetch
    // coincides with the write of the same byte and must see the old value.
    wdat[0] = 8'hE0; wdat[1] = 8'hE1; wdat[2] = 8'hE2; wdat[3] = 8'hE3;
    fork
      write_burst(4'd10, 16'h1400, 8'd3, BURST_INCR, 3, 0);
      begin
        @(negedge clk);
        read_burst(4'd11, 16'h1400, 8'd3, BURST_INCR, 0);
      end
    join
    read_burst(4'd12, 16'h1400, 8'd3, BURST_INCR, 0);

    // 6b: reset in the middle of a write burst; completed beats stay written.
    send_aw(4'd13, 16'h1100, 8'd3, BURST_INCR);
    send_w(8'h5A, 1'b1, 1'b0);
    send_w(8'h5B, 1'b1, 1'b0);
    ref_mem[16'h0100] = 8'h5A;
    ref_mem[16'h0101] = 8'h5B;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_aw_ready", 32'(miso.aw_ready), 1);
    check("midrst_w_ready",  32'(miso.w_ready), 0);
    check("midrst_b_valid",  32'(miso.b_valid), 0);
    repeat (3) @(negedge clk);
    check("midrst_no_b", 32'(miso.b_valid), 0);
    read_burst(4'd14, 16'h1100, 8'd3, BURST_INCR, 0);

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      logic [15:0] a;
      logic [7:0]  l;
      burst_e      b;
      int          sel;
      sel = $urandom_range(0, 3);
      if (sel < 2)       a = BASE + 16'($urandom_range(0, DEPTH - 1));
      else if (sel == 2) a = 16'h0FF8 + 16'($urandom_range(0, 15));
      else               a = 16'h1FF8 + 16'($urandom_range(0, 15));
      l = 8'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      b = (sel < 5) ? BURST_INCR : (sel == 5) ? BURST_FIXED : (sel == 6) ? BURST_WRAP : BURST_RSVD;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(l); i++) begin
          wdat[i] = 8'($urandom);
          wstb[i] = ($urandom_range(0, 3) != 0);
        end
        write_burst(4'($urandom), a, l, b,
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : int'(l),
                    int'($urandom_range(0, 2)));
      end else begin
        read_burst(4'($urandom), a, l, b, 2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
